// File: rtl/multicycle_controller.sv
// Control FSM for the multicycle RV32I core: one shared memory port, one shared ALU.
// Define MCCTRL_ILLEGAL_TRAP_EN to trap unsupported opcodes in a TRAP state instead of treating them as NOPs.
module multicycle_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       MemReq,
    output logic       AdrSrc,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic       Illegal
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMREAD = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXECR   = 4'd6,
        EXECI   = 4'd7,
        ALUWB   = 4'd8,
        BEQ     = 4'd9,
`ifdef MCCTRL_ILLEGAL_TRAP_EN
        JAL     = 4'd10,
        TRAP    = 4'd11
`else
        JAL     = 4'd10
`endif
    } state_t;

    state_t     state;
    logic       pc_update, branch;
    logic [1:0] alu_op;
    logic       mem_req_s, ir_write_s, mem_write_s, reg_write_s;

    // Memory handshake: MemReq is held with a stable address (and data/MemWrite for
    // stores) until the cycle MemReady is 1; that cycle completes the access.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FETCH;
        end else begin
            case (state)
                FETCH:   if (MemReady) state <= DECODE;
                DECODE: begin
                    case (op)
                        7'b0000011, 7'b0100011: state <= MEMADR;
                        7'b0110011:             state <= EXECR;
                        7'b0010011:             state <= EXECI;
                        7'b1100011:             state <= BEQ;
                        7'b1101111:             state <= JAL;
`ifdef MCCTRL_ILLEGAL_TRAP_EN
                        default:                state <= TRAP;
`else
                        default:                state <= FETCH;
`endif
                    endcase
                end
                MEMADR:  state <= op[5] ? MEMWR : MEMREAD;
                MEMREAD: if (MemReady) state <= MEMWB;
                MEMWB:   state <= FETCH;
                MEMWR:   if (MemReady) state <= FETCH;
                EXECR:   state <= ALUWB;
                EXECI:   state <= ALUWB;
                ALUWB:   state <= FETCH;
                BEQ:     state <= FETCH;
                JAL:     state <= ALUWB;
`ifdef MCCTRL_ILLEGAL_TRAP_EN
                TRAP:    state <= TRAP;
`endif
                default: state <= FETCH;
            endcase
        end
    end

    always_comb begin
        mem_req_s   = 1'b0;
        ir_write_s  = 1'b0;
        mem_write_s = 1'b0;
        reg_write_s = 1'b0;
        pc_update   = 1'b0;
        branch      = 1'b0;
        alu_op      = 2'b00;
        AdrSrc      = 1'b0;
        ResultSrc   = 2'b00;
        ALUSrcA     = 2'b00;
        ALUSrcB     = 2'b00;
        case (state)
            FETCH: begin
                mem_req_s  = 1'b1;
                ALUSrcB    = 2'b10;
                ResultSrc  = 2'b10;
                ir_write_s = MemReady;
                pc_update  = MemReady;
            end
            DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
            end
            MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            MEMREAD: begin
                mem_req_s = 1'b1;
                AdrSrc    = 1'b1;
            end
            MEMWB: begin
                ResultSrc   = 2'b01;
                reg_write_s = 1'b1;
            end
            MEMWR: begin
                mem_req_s   = 1'b1;
                mem_write_s = 1'b1;
                AdrSrc      = 1'b1;
            end
            EXECR: begin
                ALUSrcA = 2'b10;
                alu_op  = 2'b10;
            end
            EXECI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                alu_op  = 2'b10;
            end
            ALUWB:   reg_write_s = 1'b1;
            BEQ: begin
                ALUSrcA = 2'b10;
                alu_op  = 2'b01;
                branch  = 1'b1;
            end
            JAL: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                pc_update = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        case (op)
            7'b0100011: ImmSrc = 2'b01;
            7'b1100011: ImmSrc = 2'b10;
            7'b1101111: ImmSrc = 2'b11;
            default:    ImmSrc = 2'b00;
        endcase
    end

    always_comb begin
        case (alu_op)
            2'b01:   ALUControl = 3'b001;
            2'b10: begin
                case (funct3)
                    // Only R-type (op[5]=1) can subtract; addi ignores instr[30].
                    3'b000:  ALUControl = (funct7b5 & op[5]) ? 3'b001 : 3'b000;
                    3'b010:  ALUControl = 3'b101;
                    3'b110:  ALUControl = 3'b011;
                    3'b111:  ALUControl = 3'b010;
                    default: ALUControl = 3'b000;
                endcase
            end
            default: ALUControl = 3'b000;
        endcase
    end

    // Reset masks every side effect, even if the state register holds a mid-instruction value.
    assign MemReq   = mem_req_s & ~reset;
    assign IRWrite  = ir_write_s & ~reset;
    assign MemWrite = mem_write_s & ~reset;
    assign RegWrite = reg_write_s & ~reset;
    assign PCWrite  = (pc_update | (branch & Zero)) & ~reset;

`ifdef MCCTRL_ILLEGAL_TRAP_EN
    assign Illegal = (state == TRAP);
`else
    assign Illegal = 1'b0;
`endif

endmodule
